// File: rtl/audio_rec_ctrl.sv
// ---------------------------------------------------------------------------
// audio_rec_ctrl
//   Record/playback sequencer between a multi-channel sample path and an
//   SDRAM controller exposing one write FIFO and one read FIFO.
//   Record  : each captured frame is split into NUM_CH 16-bit FIFO words,
//             channel 0 first, with samples MSB-aligned in the word.
//   Playback: NUM_CH read-FIFO words are gathered into one DAC frame per
//             dac_req, with one-shot or looped replay of the recording.
//
// Ports
//   clk50M, reset_n          clock, asynchronous active-low reset
//   rec_req/play_req/stop_req  1-cycle command pulses (stop > rec > play)
//   loop_en                  restart playback at the end of the recording
//   adc_valid, adc_data      new capture frame strobe and data (ch0 in LSBs)
//   dac_req                  DAC asks for the next frame
//   rd_avail                 read FIFO holds at least NUM_CH words
//   wr_en, wr_data           write-FIFO interface
//   rd_en, rd_data           read-FIFO interface (data one cycle after rd_en)
//   dac_data, dac_valid      playback frame and its update strobe
//   wr_load, rd_load         1-cycle SDRAM address reload pulses
//   busy_rec, busy_play      state decode
//   rec_done, rec_len        recording finished / words stored
//   overrun, underrun        sticky error flags
// ---------------------------------------------------------------------------
module audio_rec_ctrl #(
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned LEN_W       = 22,
  parameter int unsigned MAX_WORDS   = 32'h0010_0000,
  parameter int unsigned PRELOAD_CYC = 1024
) (
  input  logic                       clk50M,
  input  logic                       reset_n,
  input  logic                       rec_req,
  input  logic                       play_req,
  input  logic                       stop_req,
  input  logic                       loop_en,
  input  logic                       adc_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
  input  logic                       dac_req,
  input  logic                       rd_avail,
  output logic                       wr_en,
  output logic [15:0]                wr_data,
  output logic                       rd_en,
  input  logic [15:0]                rd_data,
  output logic [NUM_CH*SAMPLE_W-1:0] dac_data,
  output logic                       dac_valid,
  output logic                       wr_load,
  output logic                       rd_load,
  output logic                       busy_rec,
  output logic                       busy_play,
  output logic                       rec_done,
  output logic [LEN_W-1:0]           rec_len,
  output logic                       overrun,
  output logic                       underrun
);

  localparam int unsigned FRAME_W = NUM_CH * SAMPLE_W;
  localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W   = $clog2(NUM_CH + 1);
  localparam int unsigned WAIT_W  = (PRELOAD_CYC > 1) ? $clog2(PRELOAD_CYC) : 1;

  localparam logic [LEN_W:0]    MAX_EXT   = (LEN_W+1)'(MAX_WORDS);
  localparam logic [LEN_W:0]    NCH_EXT   = (LEN_W+1)'(NUM_CH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]  NCH_CNT   = CNT_W'(NUM_CH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PRELOAD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REC_LOAD, S_REC, S_PLAY_LOAD, S_PLAY_WAIT, S_PLAY
  } state_e;

  // Sample placed in the upper bits of a FIFO word, low bits zero.
  function automatic logic [15:0] pack_word(input logic [SAMPLE_W-1:0] s);
    logic [15:0] w;
    w = 16'(s);
    return w << (16 - SAMPLE_W);
  endfunction

  // Upper SAMPLE_W bits of a FIFO word.
  function automatic logic [SAMPLE_W-1:0] top_bits(input logic [15:0] w);
    return w[15 -: SAMPLE_W];
  endfunction

  // Play counter advance by one frame, saturating at all ones.
  function automatic logic [LEN_W-1:0] sat_add_ch(input logic [LEN_W-1:0] a);
    logic [LEN_W:0] sum;
    sum = {1'b0, a} + NCH_EXT;
    if (sum[LEN_W]) begin
      return {LEN_W{1'b1}};
    end else begin
      return sum[LEN_W-1:0];
    end
  endfunction

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    wcnt_q, wcnt_d;
  logic [LEN_W-1:0]    pcnt_q, pcnt_d;
  logic [LEN_W-1:0]    rec_len_q, rec_len_d;
  logic                rec_done_q, rec_done_d;
  logic                overrun_q, overrun_d;
  logic                underrun_q, underrun_d;
  logic [FRAME_W-1:0]  rec_frame_q, rec_frame_d;
  logic                ser_busy_q, ser_busy_d;
  logic [IDX_W-1:0]    ser_idx_q, ser_idx_d;
  logic                wr_en_q, wr_en_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                wr_load_q, wr_load_d;
  logic                rd_load_q, rd_load_d;
  logic                rd_en_q, rd_en_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic                cap_pend_q, cap_pend_d;
  logic [IDX_W-1:0]    cap_idx_q, cap_idx_d;
  logic                gather_q, gather_d;
  logic [FRAME_W-1:0]  play_frame_q, play_frame_d;
  logic [FRAME_W-1:0]  dac_data_q, dac_data_d;
  logic                dac_valid_q, dac_valid_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic                is_rec_s;
  logic [FRAME_W-1:0]  frame_tmp_s;
  logic [LEN_W-1:0]    pcnt_next_s;

  assign is_rec_s = (state_q == S_REC_LOAD) || (state_q == S_REC);

  // Next-state and output decode for the sequencer.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    pcnt_d       = pcnt_q;
    rec_len_d    = rec_len_q;
    rec_done_d   = rec_done_q;
    overrun_d    = overrun_q;
    underrun_d   = underrun_q;
    rec_frame_d  = rec_frame_q;
    ser_busy_d   = ser_busy_q;
    ser_idx_d    = ser_idx_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    wr_load_d    = 1'b0;
    rd_load_d    = 1'b0;
    rd_en_d      = 1'b0;
    rd_cnt_d     = rd_cnt_q;
    cap_pend_d   = rd_en_q;      // read data arrives one cycle after rd_en
    cap_idx_d    = cap_idx_q;
    gather_d     = gather_q;
    play_frame_d = play_frame_q;
    dac_data_d   = dac_data_q;
    dac_valid_d  = 1'b0;
    wait_cnt_d   = wait_cnt_q;
    frame_tmp_s  = play_frame_q;
    pcnt_next_s  = sat_add_ch(pcnt_q);

    if (stop_req) begin
      if (is_rec_s) begin
        rec_len_d  = wcnt_q;
        rec_done_d = 1'b1;
      end else begin
        rec_done_d = rec_done_q;
      end
      state_d    = S_IDLE;
      ser_busy_d = 1'b0;
      ser_idx_d  = {IDX_W{1'b0}};
      gather_d   = 1'b0;
      rd_cnt_d   = {CNT_W{1'b0}};
      cap_idx_d  = {IDX_W{1'b0}};
    end else if (rec_req) begin
      state_d    = S_REC_LOAD;
      wr_load_d  = 1'b1;
      wcnt_d     = {LEN_W{1'b0}};
      rec_done_d = 1'b0;
      overrun_d  = 1'b0;
      ser_busy_d = 1'b0;
      ser_idx_d  = {IDX_W{1'b0}};
      gather_d   = 1'b0;
      rd_cnt_d   = {CNT_W{1'b0}};
      cap_idx_d  = {IDX_W{1'b0}};
    end else if (play_req && (rec_len_q != {LEN_W{1'b0}}) && !is_rec_s) begin
      state_d    = S_PLAY_LOAD;
      rd_load_d  = 1'b1;
      underrun_d = 1'b0;
      pcnt_d     = {LEN_W{1'b0}};
      gather_d   = 1'b0;
      rd_cnt_d   = {CNT_W{1'b0}};
      cap_idx_d  = {IDX_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_REC_LOAD: begin
          wcnt_d  = {LEN_W{1'b0}};
          state_d = S_REC;
        end
        S_REC: begin
          if (ser_busy_q) begin
            // Remaining channels of the latched frame; a new frame now is lost.
            wr_en_d   = 1'b1;
            wr_data_d = pack_word(rec_frame_q[ser_idx_q*SAMPLE_W +: SAMPLE_W]);
            wcnt_d    = wcnt_q + LEN_W'(1);
            if (ser_idx_q == LAST_IDX) begin
              ser_busy_d = 1'b0;
              ser_idx_d  = {IDX_W{1'b0}};
            end else begin
              ser_idx_d  = ser_idx_q + IDX_W'(1);
            end
            if (adc_valid) begin
              overrun_d = 1'b1;
            end else begin
              overrun_d = overrun_q;
            end
          end else if (adc_valid) begin
            if (({1'b0, wcnt_q} + NCH_EXT) <= MAX_EXT) begin
              // Channel 0 goes out immediately, the rest follow back to back.
              rec_frame_d = adc_data;
              wr_en_d     = 1'b1;
              wr_data_d   = pack_word(adc_data[SAMPLE_W-1:0]);
              wcnt_d      = wcnt_q + LEN_W'(1);
              if (NUM_CH > 1) begin
                ser_busy_d = 1'b1;
                ser_idx_d  = IDX_W'(1);
              end else begin
                ser_busy_d = 1'b0;
              end
            end else begin
              // Memory full: only whole frames are ever stored.
              rec_len_d  = wcnt_q;
              rec_done_d = 1'b1;
              state_d    = S_IDLE;
            end
          end else begin
            state_d = S_REC;
          end
        end
        S_PLAY_LOAD: begin
          wait_cnt_d = {WAIT_W{1'b0}};
          state_d    = S_PLAY_WAIT;
        end
        S_PLAY_WAIT: begin
          // SDRAM is still filling the read FIFO: answer requests with silence.
          if (dac_req) begin
            dac_data_d  = {FRAME_W{1'b0}};
            dac_valid_d = 1'b1;
          end else begin
            dac_valid_d = 1'b0;
          end
          if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_d = {WAIT_W{1'b0}};
            state_d    = S_PLAY;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        S_PLAY: begin
          if (gather_q) begin
            if (rd_cnt_q != NCH_CNT) begin
              rd_en_d  = 1'b1;
              rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end else begin
              rd_en_d  = 1'b0;
            end
            if (cap_pend_q) begin
              frame_tmp_s[cap_idx_q*SAMPLE_W +: SAMPLE_W] = top_bits(rd_data);
              play_frame_d = frame_tmp_s;
              if (cap_idx_q == LAST_IDX) begin
                dac_data_d  = frame_tmp_s;
                dac_valid_d = 1'b1;
                gather_d    = 1'b0;
                rd_cnt_d    = {CNT_W{1'b0}};
                cap_idx_d   = {IDX_W{1'b0}};
                pcnt_d      = pcnt_next_s;
                if (pcnt_next_s >= rec_len_q) begin
                  if (loop_en) begin
                    rd_load_d  = 1'b1;
                    pcnt_d     = {LEN_W{1'b0}};
                    wait_cnt_d = {WAIT_W{1'b0}};
                    state_d    = S_PLAY_WAIT;
                  end else begin
                    state_d    = S_IDLE;
                  end
                end else begin
                  state_d = S_PLAY;
                end
              end else begin
                cap_idx_d = cap_idx_q + IDX_W'(1);
              end
            end else begin
              cap_idx_d = cap_idx_q;
            end
          end else if (dac_req) begin
            if (!rd_avail) begin
              dac_data_d  = {FRAME_W{1'b0}};
              dac_valid_d = 1'b1;
              underrun_d  = 1'b1;
            end else begin
              gather_d  = 1'b1;
              rd_en_d   = 1'b1;
              rd_cnt_d  = CNT_W'(1);
              cap_idx_d = {IDX_W{1'b0}};
            end
          end else begin
            state_d = S_PLAY;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wcnt_q       <= {LEN_W{1'b0}};
      pcnt_q       <= {LEN_W{1'b0}};
      rec_len_q    <= {LEN_W{1'b0}};
      rec_done_q   <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      rec_frame_q  <= {FRAME_W{1'b0}};
      ser_busy_q   <= 1'b0;
      ser_idx_q    <= {IDX_W{1'b0}};
      wr_en_q      <= 1'b0;
      wr_data_q    <= 16'h0000;
      wr_load_q    <= 1'b0;
      rd_load_q    <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_cnt_q     <= {CNT_W{1'b0}};
      cap_pend_q   <= 1'b0;
      cap_idx_q    <= {IDX_W{1'b0}};
      gather_q     <= 1'b0;
      play_frame_q <= {FRAME_W{1'b0}};
      dac_data_q   <= {FRAME_W{1'b0}};
      dac_valid_q  <= 1'b0;
      wait_cnt_q   <= {WAIT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      pcnt_q       <= pcnt_d;
      rec_len_q    <= rec_len_d;
      rec_done_q   <= rec_done_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      rec_frame_q  <= rec_frame_d;
      ser_busy_q   <= ser_busy_d;
      ser_idx_q    <= ser_idx_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_load_q    <= wr_load_d;
      rd_load_q    <= rd_load_d;
      rd_en_q      <= rd_en_d;
      rd_cnt_q     <= rd_cnt_d;
      cap_pend_q   <= cap_pend_d;
      cap_idx_q    <= cap_idx_d;
      gather_q     <= gather_d;
      play_frame_q <= play_frame_d;
      dac_data_q   <= dac_data_d;
      dac_valid_q  <= dac_valid_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign rd_en     = rd_en_q;
  assign dac_data  = dac_data_q;
  assign dac_valid = dac_valid_q;
  assign wr_load   = wr_load_q;
  assign rd_load   = rd_load_q;
  assign busy_rec  = is_rec_s;
  assign busy_play = (state_q == S_PLAY_LOAD) || (state_q == S_PLAY_WAIT) ||
                     (state_q == S_PLAY);
  assign rec_done  = rec_done_q;
  assign rec_len   = rec_len_q;
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;

endmodule
